// File: rtl/pointwise_conv_engine.sv
// Pointwise (1x1) convolution engine with requantisation.
// For every output channel, pixel (row, col) and input channel it reads one activation and one
// weight, accumulates their signed product on top of the channel bias, then rounds, shifts,
// optionally applies ReLU and saturates the result before writing it out.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, shift, relu_en layer request; shift/relu_en are latched with start
//   busy, done            layer in progress / one-cycle completion pulse
//   act_*                 activation read port (address in, data back after MEM_LATENCY)
//   w_*                   weight read port
//   b_*                   bias read port
//   out_*                 output write port
module pointwise_conv_engine #(
  parameter int unsigned IN_CHANNELS    = 192,
  parameter int unsigned OUT_CHANNELS   = 32,
  parameter int unsigned HEIGHT         = 28,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BIAS_WIDTH     = 16,
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned ACT_ADDR_WIDTH = 18,
  parameter int unsigned W_ADDR_WIDTH   = 13,
  parameter int unsigned B_ADDR_WIDTH   = 5,
  parameter int unsigned OUT_ADDR_WIDTH = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4:0]                shift,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      done,
  output logic                      act_rd_en,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  input  logic [DATA_WIDTH-1:0]     act_data,
  output logic                      w_rd_en,
  output logic [W_ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]     w_data,
  output logic                      b_rd_en,
  output logic [B_ADDR_WIDTH-1:0]   b_addr,
  input  logic [BIAS_WIDTH-1:0]     b_data,
  output logic                      out_we,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]     out_data
);

  localparam int unsigned ICW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int unsigned OCW = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int unsigned RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LW  = $clog2(MEM_LATENCY + 1);
  localparam int unsigned AW1 = ACC_WIDTH + 1;
  localparam int unsigned HW  = HEIGHT * WIDTH;

  localparam logic signed [ACC_WIDTH:0] SatMax = AW1'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SatMin = ~SatMax;

  typedef enum logic [2:0] {StIdle, StBias, StMac, StDrain, StWrite, StDone} state_e;

  state_e                      state_q, state_d;
  logic [ICW-1:0]              in_c_q;
  logic [OCW-1:0]              out_c_q;
  logic [RW-1:0]               row_q;
  logic [CW-1:0]               col_q;
  logic [LW-1:0]               cnt_q;
  logic [4:0]                  shift_q;
  logic                        relu_q;
  logic signed [ACC_WIDTH-1:0] bias_q, acc_q;
  logic [MEM_LATENCY-1:0]      vld_q;
  logic [ACT_ADDR_WIDTH-1:0]   act_addr_q;
  logic [W_ADDR_WIDTH-1:0]     w_addr_q;
  logic [B_ADDR_WIDTH-1:0]     b_addr_q;
  logic [OUT_ADDR_WIDTH-1:0]   out_addr_q;
  logic [DATA_WIDTH-1:0]       out_data_q;

  logic issue, ret, last_in, last_col, last_row, last_oc, cnt_is_l, cnt_is_lm1;
  logic [MEM_LATENCY:0]        vld_ext;
  logic signed [ACC_WIDTH-1:0] act_ext, w_ext, prod, bias_ext;
  logic signed [ACC_WIDTH:0]   rnd_sum, r;
  logic [DATA_WIDTH-1:0]       req_q8;

  assign last_in    = in_c_q == ICW'(IN_CHANNELS - 1);
  assign last_col   = col_q == CW'(WIDTH - 1);
  assign last_row   = row_q == RW'(HEIGHT - 1);
  assign last_oc    = out_c_q == OCW'(OUT_CHANNELS - 1);
  assign cnt_is_l   = cnt_q == LW'(MEM_LATENCY);
  assign cnt_is_lm1 = cnt_q == LW'(MEM_LATENCY - 1);

  // Valid tags travel alongside the outstanding reads; the oldest tag marks returning data.
  assign vld_ext = {vld_q, issue};
  assign ret     = vld_q[MEM_LATENCY-1];

  assign act_ext  = ACC_WIDTH'($signed(act_data));
  assign w_ext    = ACC_WIDTH'($signed(w_data));
  assign prod     = act_ext * w_ext;
  assign bias_ext = ACC_WIDTH'($signed(b_data));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    issue   = 1'b0;
    b_rd_en = 1'b0;
    out_we  = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StBias;
      StBias: begin
        busy    = 1'b1;
        b_rd_en = (cnt_q == '0);
        if (cnt_is_l) state_d = StMac;
      end
      StMac: begin
        busy  = 1'b1;
        issue = 1'b1;
        if (last_in) state_d = StDrain;
      end
      StDrain: begin
        busy = 1'b1;
        if (cnt_is_lm1) state_d = StWrite;
      end
      StWrite: begin
        busy   = 1'b1;
        out_we = 1'b1;
        if (last_col && last_row) state_d = last_oc ? StDone : StBias;
        else                      state_d = StMac;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign act_rd_en = issue;
  assign w_rd_en   = issue;

  // Addresses are live only while their port is active and hold their last value otherwise.
  assign act_addr = issue ? ACT_ADDR_WIDTH'(in_c_q) * ACT_ADDR_WIDTH'(HW)
                          + ACT_ADDR_WIDTH'(row_q) * ACT_ADDR_WIDTH'(WIDTH)
                          + ACT_ADDR_WIDTH'(col_q) : act_addr_q;
  assign w_addr   = issue ? W_ADDR_WIDTH'(out_c_q) * W_ADDR_WIDTH'(IN_CHANNELS)
                          + W_ADDR_WIDTH'(in_c_q) : w_addr_q;
  assign b_addr   = b_rd_en ? B_ADDR_WIDTH'(out_c_q) : b_addr_q;
  assign out_addr = out_we ? OUT_ADDR_WIDTH'(out_c_q) * OUT_ADDR_WIDTH'(HW)
                           + OUT_ADDR_WIDTH'(row_q) * OUT_ADDR_WIDTH'(WIDTH)
                           + OUT_ADDR_WIDTH'(col_q) : out_addr_q;
  assign out_data = out_we ? req_q8 : out_data_q;

  // Requantisation: rounding add one bit wider than the accumulator so it cannot overflow.
  always_comb begin
    rnd_sum = {acc_q[ACC_WIDTH-1], acc_q};
    r       = rnd_sum;
    if (shift_q != 5'd0) begin
      rnd_sum = rnd_sum + (AW1'(1) << (shift_q - 5'd1));
      r       = rnd_sum >>> shift_q;
    end
    if (relu_q && r[ACC_WIDTH]) r = '0;
    if (r > SatMax)      req_q8 = SatMax[DATA_WIDTH-1:0];
    else if (r < SatMin) req_q8 = SatMin[DATA_WIDTH-1:0];
    else                 req_q8 = r[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_c_q     <= '0;
      out_c_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      bias_q     <= '0;
      acc_q      <= '0;
      vld_q      <= '0;
      act_addr_q <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_ext[MEM_LATENCY-1:0];
      act_addr_q <= act_addr;
      w_addr_q   <= w_addr;
      b_addr_q   <= b_addr;
      out_addr_q <= out_addr;
      out_data_q <= out_data;

      // First MAC cycle of a pixel seeds the accumulator; no reads are in flight then.
      if (state_q == StMac && in_c_q == '0) acc_q <= bias_q;
      else if (ret)                          acc_q <= acc_q + prod;

      case (state_q)
        StIdle: begin
          if (start) begin
            shift_q <= shift;
            relu_q  <= relu_en;
            in_c_q  <= '0;
            out_c_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StBias: begin
          cnt_q <= cnt_is_l ? '0 : cnt_q + LW'(1);
          if (cnt_is_l) bias_q <= bias_ext;
        end
        StMac: begin
          in_c_q <= last_in ? '0 : in_c_q + ICW'(1);
          cnt_q  <= '0;
        end
        StDrain: cnt_q <= cnt_is_lm1 ? '0 : cnt_q + LW'(1);
        StWrite: begin
          col_q <= last_col ? '0 : col_q + CW'(1);
          if (last_col) begin
            row_q <= last_row ? '0 : row_q + RW'(1);
            if (last_row) out_c_q <= last_oc ? '0 : out_c_q + OCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pointwise_conv_engine.sv
module tb_pointwise_conv_engine;
  localparam int CI = 4, CO = 2, H = 2, W = 3, HW = 6, NPIX = 12;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, relu_en = 1'b0, clr = 1'b0;
  logic [4:0] shift = 5'd0;
  always #5 clk = ~clk;

  logic [1:0]  busy_v, done_v, act_en_v, w_en_v, b_en_v, we_v;
  logic [17:0] act_addr_v [2];
  logic [12:0] w_addr_v [2];
  logic [4:0]  b_addr_v [2];
  logic [14:0] out_addr_v [2];
  logic [7:0]  act_data_v [2], w_data_v [2], out_data_v [2];
  logic [15:0] b_data_v [2];

  logic [7:0]  act_mem [64];
  logic [7:0]  w_mem [16];
  logic [15:0] b_mem [4];

  // Instance 0 sees latency-1 memories, instance 1 latency-3 memories.
  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int unsigned Lat = (gi == 0) ? 1 : 3;
    logic [17:0]    ap [Lat];
    logic [12:0]    wp [Lat];
    logic [4:0]     bp [Lat];
    logic [Lat-1:0] ae, wen, be;
    always @(posedge clk) begin
      ap[0] <= act_addr_v[gi]; wp[0] <= w_addr_v[gi]; bp[0] <= b_addr_v[gi];
      ae[0] <= act_en_v[gi];   wen[0] <= w_en_v[gi];  be[0] <= b_en_v[gi];
      for (int k = 1; k < Lat; k++) begin
        ap[k] <= ap[k-1]; wp[k] <= wp[k-1]; bp[k] <= bp[k-1];
        ae[k] <= ae[k-1]; wen[k] <= wen[k-1]; be[k] <= be[k-1];
      end
    end
    assign act_data_v[gi] = ae[Lat-1]  ? act_mem[ap[Lat-1][5:0]] : 8'h55;
    assign w_data_v[gi]   = wen[Lat-1] ? w_mem[wp[Lat-1][3:0]]   : 8'h55;
    assign b_data_v[gi]   = be[Lat-1]  ? b_mem[bp[Lat-1][1:0]]   : 16'h5555;

    pointwise_conv_engine #(
      .IN_CHANNELS(CI), .OUT_CHANNELS(CO), .HEIGHT(H), .WIDTH(W), .MEM_LATENCY(Lat)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .shift(shift), .relu_en(relu_en),
      .busy(busy_v[gi]), .done(done_v[gi]),
      .act_rd_en(act_en_v[gi]), .act_addr(act_addr_v[gi]), .act_data(act_data_v[gi]),
      .w_rd_en(w_en_v[gi]), .w_addr(w_addr_v[gi]), .w_data(w_data_v[gi]),
      .b_rd_en(b_en_v[gi]), .b_addr(b_addr_v[gi]), .b_data(b_data_v[gi]),
      .out_we(we_v[gi]), .out_addr(out_addr_v[gi]), .out_data(out_data_v[gi])
    );
  end

  // Output monitor, sampled on the falling edge.
  int cyc = 0;
  int wr_n [2], busy_n [2], done_n [2], last_busy [2], done_t [2], done_busy [2];
  logic [14:0] wa [2][NPIX];
  logic [7:0]  wd [2][NPIX];
  int          wt [2][NPIX];
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        wr_n[i] = 0; busy_n[i] = 0; done_n[i] = 0; last_busy[i] = 0; done_t[i] = 0;
        done_busy[i] = 0;
      end else begin
        if (busy_v[i]) begin busy_n[i]++; last_busy[i] = cyc; end
        if (done_v[i]) begin
          done_n[i]++; done_t[i] = cyc;
          if (busy_v[i]) done_busy[i]++;
        end
        if (we_v[i]) begin
          if (wr_n[i] < NPIX) begin
            wa[i][wr_n[i]] = out_addr_v[i]; wd[i][wr_n[i]] = out_data_v[i];
            wt[i][wr_n[i]] = cyc;
          end
          wr_n[i]++;
        end
      end
    end
  end

  int checks = 0, failures = 0;
  int exp_d [NPIX];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int requant(input longint acc, input int sh, input bit rl);
    longint r;
    r = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
    if (rl && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  // Reference: out[oc][pix] = requant(bias[oc] + sum_ic act[ic][pix] * w[oc][ic]), acc mod 2^32.
  task automatic model(input int sh, input bit rl);
    for (int oc = 0; oc < CO; oc++)
      for (int p = 0; p < HW; p++) begin
        longint sum;
        int     a32;
        sum = longint'($signed(b_mem[oc]));
        for (int ic = 0; ic < CI; ic++) begin
          int a, wv;
          a  = int'($signed(act_mem[ic*HW+p]));
          wv = int'($signed(w_mem[oc*CI+ic]));
          sum += longint'(a * wv);
        end
        a32 = int'(sum);
        exp_d[oc*HW+p] = requant(longint'(a32), sh, rl);
      end
  endtask

  task automatic fill(input int a, input int wv, input int b0, input int b1);
    for (int k = 0; k < 64; k++) act_mem[k] = 8'(a);
    for (int k = 0; k < 16; k++) w_mem[k] = 8'(wv);
    b_mem[0] = 16'(b0); b_mem[1] = 16'(b1); b_mem[2] = 16'h0; b_mem[3] = 16'h0;
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_busy"}, busy_v[i], 0);     chk({tag, "_done"}, done_v[i], 0);
      chk({tag, "_we"}, we_v[i], 0);         chk({tag, "_act_en"}, act_en_v[i], 0);
      chk({tag, "_w_en"}, w_en_v[i], 0);     chk({tag, "_b_en"}, b_en_v[i], 0);
      chk({tag, "_act_addr"}, act_addr_v[i], 0); chk({tag, "_w_addr"}, w_addr_v[i], 0);
      chk({tag, "_b_addr"}, b_addr_v[i], 0); chk({tag, "_out_addr"}, out_addr_v[i], 0);
      chk({tag, "_out_data"}, out_data_v[i], 0);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic run_layer(input int sh, input bit rl, input bit mid, input string tag);
    int n;
    model(sh, rl);
    clear_mon();
    chk({tag, "_idle"}, busy_v, 0);
    start = 1'b1; shift = 5'(sh); relu_en = rl;
    @(posedge clk); #1 start = 1'b0; shift = ~5'(sh); relu_en = ~rl;
    chk({tag, "_busy_rise"}, busy_v, 2'b11);
    if (mid) begin
      repeat (15) @(posedge clk);
      #1 start = 1'b1; shift = 5'd7; relu_en = ~rl;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    while ((done_n[0] == 0 || done_n[1] == 0) && n < 1000) begin
      @(posedge clk); n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_timeout"}, (n < 1000), 1);
    for (int i = 0; i < 2; i++) begin
      int lat, lim;
      lat = (i == 0) ? 1 : 3;
      chk({tag, "_wr_count"}, wr_n[i], NPIX);
      chk({tag, "_busy_cycles"}, busy_n[i], CO * ((lat + 1) + HW * (CI + lat + 1)));
      chk({tag, "_done_count"}, done_n[i], 1);
      chk({tag, "_done_after_busy"}, done_t[i], last_busy[i] + 1);
      chk({tag, "_done_while_busy"}, done_busy[i], 0);
      lim = (wr_n[i] < NPIX) ? wr_n[i] : NPIX;
      for (int k = 0; k < lim; k++) begin
        chk({tag, "_addr"}, wa[i][k], k);
        chk({tag, "_data"}, $signed(wd[i][k]), exp_d[k]);
        if (k > 0)
          chk({tag, "_gap"}, wt[i][k] - wt[i][k-1],
              (k % HW == 0) ? (CI + lat + 1) + (lat + 1) : (CI + lat + 1));
      end
    end
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2 chk_reset("reset");
    @(negedge clk); rst_n = 1'b1;

    fill(1, 1, 0, 0);       run_layer(0, 1'b0, 1'b0, "ones");
    fill(1, 1, -10, 3);     run_layer(0, 1'b1, 1'b0, "bias_relu");
    run_layer(0, 1'b0, 1'b0, "bias_norelu");
    fill(127, 127, 0, 0);   run_layer(0, 1'b0, 1'b0, "sat_pos");
    run_layer(9, 1'b0, 1'b0, "round9");
    fill(-128, 127, 0, 0);  run_layer(0, 1'b0, 1'b0, "sat_neg");
    fill(3, -2, 100, -50);  run_layer(2, 1'b0, 1'b1, "mid_start");

    for (int r = 0; r < 6; r++) begin
      int sh;
      for (int k = 0; k < 64; k++) act_mem[k] = 8'($urandom);
      for (int k = 0; k < 16; k++) w_mem[k] = 8'($urandom);
      for (int k = 0; k < 4; k++) b_mem[k] = 16'($urandom_range(0, 8000) - 4000);
      sh = (r == 0) ? 31 : ((r == 1) ? 0 : int'($urandom_range(1, 12)));
      run_layer(sh, 1'($urandom_range(0, 1)), 1'b0, "random");
    end

    // Reset during channel 1, then a full rerun.
    fill(1, 1, 0, 0);
    clear_mon();
    start = 1'b1; shift = 5'd0; relu_en = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (wr_n[0] < 7 && n < 1000) begin @(posedge clk); n++; end
    chk("midrst_reach_ch1", (n < 1000), 1);
    #3 rst_n = 1'b0;
    #1 chk_reset("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_we0", wr_n[0], 0);
    chk("midrst_no_we1", wr_n[1], 0);
    chk("midrst_idle", busy_v, 0);
    run_layer(0, 1'b0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pointwise_conv_engine.md
# pointwise_conv_engine

Parametrised signed 1x1 (pointwise) convolution engine with requantisation, the next-generation pointwise stage of the gesture-recognition CNN datapath. It reads an activation tensor and a weight matrix from external read-only memories of configurable read latency. It accumulates signed products on top of a per-channel bias, then rounds, shifts, optionally applies ReLU and saturates each result. Results go to an external output memory. It sits between the depthwise stage output buffer and the next layer's input buffer, and is driven by the layer sequencer via a start/busy/done handshake.

## Interface
- IN_CHANNELS, 192, input channels (C_in ≥ 1)
- OUT_CHANNELS, 32, output channels (C_out ≥ 1)
- HEIGHT, 28, feature-map rows (H)
- WIDTH, 32, feature-map columns (W)
- DATA_WIDTH, 8, signed activation/weight/output width (DW)
- BIAS_WIDTH, 16, signed bias width
- ACC_WIDTH, 32, signed accumulator width; must be ≥ 2*DW and ≥ BIAS_WIDTH
- MEM_LATENCY, 1, read latency in cycles of all three source memories (L ≥ 1)
- ACT_ADDR_WIDTH / W_ADDR_WIDTH / B_ADDR_WIDTH / OUT_ADDR_WIDTH, 18 / 13 / 5 / 15, memory address widths
- clk  in  1  single clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- shift  in  5  requant right-shift; sampled with start
- relu_en  in  1  ReLU enable; sampled with start
- busy  out  1  high while a layer is in progress
- done  out  1  one-cycle completion pulse
- act_rd_en / act_addr / act_data  out / out / in  1 / ACT_ADDR_WIDTH / DW  activation read port
- w_rd_en / w_addr / w_data  out / out / in  1 / W_ADDR_WIDTH / DW  weight read port
- b_rd_en / b_addr / b_data  out / out / in  1 / B_ADDR_WIDTH / BIAS_WIDTH  bias read port
- out_we / out_addr / out_data  out / out / out  1 / OUT_ADDR_WIDTH / DW  output write port

## Operation
- States: IDLE → BIAS → MAC → DRAIN → WRITE, then one of:
  - MAC, for the next pixel;
  - BIAS, for the next channel;
  - DONE → IDLE, after the last pixel of the last channel.
- Loop order: out_c outermost, then row, then col, then in_c innermost.
- IDLE: when start=1, latch shift and relu_en, clear all counters and go to BIAS.
- BIAS: lasts L+1 cycles.
  - Cycle 0 drives b_rd_en=1 with b_addr=out_c.
  - Cycle L captures b_data into bias_reg, sign-extended.
- MAC: lasts C_in cycles.
  - Each cycle issues act_rd_en=w_rd_en=1 with act_addr=in_c*H*W+row*W+col and w_addr=out_c*C_in+in_c.
  - A valid shift register of depth L tags the returned data.
  - On each tagged return, acc += sext(act_data)*sext(w_data), signed.
  - acc is loaded with bias_reg on the first MAC cycle of each pixel.
- DRAIN: lasts L cycles; absorbs the remaining in-flight returns.
- WRITE: 1 cycle, producing out_we=1, out_addr=out_c*H*W+row*W+col, out_data=requant(acc).
- requant, applied in order:
  1. If shift>0, r = (acc + 2^(shift-1)) >>> shift (arithmetic shift); otherwise r = acc.
  2. If relu_en and r<0, r = 0.
  3. Saturate r to [-2^(DW-1), 2^(DW-1)-1].
- Arithmetic rules:
  - acc wraps modulo 2^ACC_WIDTH and has no overflow flag.
  - The rounding add is performed at ACC_WIDTH+1 bits.
- Read enables are low in every state other than the issuing cycles above. Addresses hold their last value.

## Timing
- Reset values: busy=0, done=0, out_we=0, all *_rd_en=0, all addresses 0, out_data=0, state IDLE.
- busy rises in the cycle after start is sampled.
- busy stays high for exactly T = C_out*((L+1) + H*W*(C_in+L+1)) cycles.
- done=1 for exactly one cycle, in the first cycle busy is low again. A start in that cycle is ignored.
- start while busy=1 is ignored and has no effect on counters or latched shift/relu_en.
- A new start is accepted in any IDLE cycle after done.
- out_we pulses once per output pixel, C_in+L+1 cycles apart within a channel. Addresses are strictly sequential 0 … C_out*H*W-1.
- Reset mid-operation: all outputs return to reset values asynchronously and in-flight reads are discarded. After rst_n rises, no out_we occurs until a new start.
- shift ≥ ACC_WIDTH yields 0 or -1 before ReLU and saturation; this is legal.

## Test plan
- Config C_in=4, C_out=2, H=2, W=3, L=1. Acts all 1, weights all 1, bias 0, shift 0 -> 12 writes, all out_data=4, addresses 0..11, busy high 76 cycles, single done pulse.
- Same config with bias[0]=-10, bias[1]=+3, relu_en=1 -> channel 0 outputs 0; channel 1 outputs 7. With relu_en=0 -> channel 0 outputs -6.
- Acts=127, weights=127, bias 0: shift 0 -> 127 (saturated); shift 9 -> 126 (rounded). Acts=-128, weights=127, shift 0 -> -128.
- L=3, same data as test 1 -> identical outputs. Write spacing 8 cycles. busy high 2*(4+6*8)=104 cycles.
- start pulsed mid-run with shift=7 -> results unchanged from the original shift, exactly one done.
- rst_n low during channel 1 -> outputs at reset values immediately. A subsequent start reproduces the full 12-write sequence from address 0.
